rtc_switch_conditioner: RTL and testbench

- Upstream stage of the RTC general control FSM. Produces its four mode-request levels: S0 (date edit), S1 (time edit), S2 (timer edit) and s_stop_t (stop timer).
- Takes four raw board switches/buttons. Each goes through a 2-FF synchronizer and a per-channel debouncer.
- A grant/lock arbiter guarantees at most one request level is high at a time. Priority matches the FSM's decode order: S0 > S1 > S2 > stop.

---
 rtl/rtc_switch_conditioner_if.sv | 23 ++
 rtl/rtc_switch_conditioner.sv | 148 ++++++++++++++
 tb/tb_rtc_switch_conditioner.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_switch_conditioner_if.sv
// Board-side bundle for rtc_switch_conditioner: four raw buttons in, four mode requests plus lock out.
// master = switch/board side (drives buttons), slave = conditioner (drives requests).
interface rtc_switch_conditioner_if;
    logic btn_fecha_i;
    logic btn_hora_i;
    logic btn_timer_i;
    logic btn_stop_i;
    logic s0_o;
    logic s1_o;
    logic s2_o;
    logic stop_o;
    logic lock_o;

    modport master (
        output btn_fecha_i, btn_hora_i, btn_timer_i, btn_stop_i,
        input  s0_o, s1_o, s2_o, stop_o, lock_o
    );

    modport slave (
        input  btn_fecha_i, btn_hora_i, btn_timer_i, btn_stop_i,
        output s0_o, s1_o, s2_o, stop_o, lock_o
    );
endinterface

// File: rtl/rtc_switch_conditioner.sv
// Conditions the four RTC buttons into mutually exclusive mode requests: 2-FF sync, debounce, grant arbiter.
// Optional macro SW_TOGGLE_EN: a debounced press toggles its request instead of following the level.
module rtc_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    rtc_switch_conditioner_if.slave       sw
);

    localparam int                NCH      = 4;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NCH-1:0]    LSB_ONE  = NCH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_REARM = 2'b10
    } state_e;

    // Channel index doubles as priority: 0 = fecha (highest) .. 3 = stop (lowest).
    logic [NCH-1:0] raw;
    assign raw = {sw.btn_stop_i, sw.btn_timer_i, sw.btn_hora_i, sw.btn_fecha_i};

    logic [NCH-1:0] sync1_q, sync1_d;
    logic [NCH-1:0] sync2_q, sync2_d;
    logic [NCH-1:0] deb_q,   deb_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    state_e         state_q, state_d;
    logic [1:0]     gnt_q,   gnt_d;
    logic [NCH-1:0] out_q,   out_d;
    logic [NCH-1:0] req;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // deb flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles; any agreement restarts.
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no path can infer a latch.
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef SW_TOGGLE_EN
    logic [NCH-1:0] tog_q, tog_d;
    logic           grant_event;

    // A grant issue or release wipes every other channel's toggle so nothing stale requests later.
    always_comb begin
        grant_event = ((state_q == ST_IDLE)  && (state_d == ST_GRANT)) ||
                      ((state_q == ST_GRANT) && (state_d == ST_REARM));
        tog_d = tog_q ^ (deb_d & ~deb_q);
        if (grant_event) begin
            tog_d = tog_d & (LSB_ONE << gnt_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign req = tog_q;
`else
    assign req = deb_q;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    if (req[0])      gnt_d = 2'd0;
                    else if (req[1]) gnt_d = 2'd1;
                    else if (req[2]) gnt_d = 2'd2;
                    else             gnt_d = 2'd3;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_q]) begin
                    state_d = ST_REARM;
                end
            end
            ST_REARM: begin
                // Waits on the raw debounced levels so a held button must be released first.
                if (deb_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        out_d = (state_d == ST_GRANT) ? (LSB_ONE << gnt_d) : '0;
    end

    // NOTE: counters and all state reset asynchronously so a reset mid-grant drops outputs at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            out_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
        end
    end

    assign sw.s0_o   = out_q[0];
    assign sw.s1_o   = out_q[1];
    assign sw.s2_o   = out_q[2];
    assign sw.stop_o = out_q[3];
    assign sw.lock_o = (state_q == ST_GRANT) || (state_q == ST_REARM);

endmodule

// File: tb/tb_rtc_switch_conditioner.sv
// Self-checking bench for rtc_switch_conditioner (DEBOUNCE_CYCLES=4): vector table, corner sequences,
// and randomized button activity compared every cycle against a window-based reference model.
module tb_rtc_switch_conditioner;

    localparam int D  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset;

    rtc_switch_conditioner_if sw ();

    rtc_switch_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Button vector bit order {stop, timer, hora, fecha}; output vector {lock, stop, s2, s1, s0}.
    typedef struct {
        logic [3:0] btn;
        logic [4:0] exp;
    } vec_t;

    // Reference model state: raw history (newest first), debounced levels, toggles, owner.
    logic [3:0] m_hist[$];
    logic [3:0] m_deb;
    logic [3:0] m_tog;
    logic [3:0] m_out;
    int         m_owner;
    bit         m_rearm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] get_out();
        return {sw.lock_o, sw.stop_o, sw.s2_o, sw.s1_o, sw.s0_o};
    endfunction

    function automatic logic [3:0] cur_btn();
        return {sw.btn_stop_i, sw.btn_timer_i, sw.btn_hora_i, sw.btn_fecha_i};
    endfunction

    function automatic logic [4:0] model_out();
        return {((m_owner >= 0) || m_rearm), m_out};
    endfunction

    task automatic set_btn(input logic [3:0] b);
        sw.btn_fecha_i = b[0];
        sw.btn_hora_i  = b[1];
        sw.btn_timer_i = b[2];
        sw.btn_stop_i  = b[3];
    endtask

    task automatic model_clear();
        m_hist.delete();
        for (int j = 0; j < D + 2; j++) m_hist.push_back(4'b0000);
        m_deb   = '0;
        m_tog   = '0;
        m_out   = '0;
        m_owner = -1;
        m_rearm = 1'b0;
    endtask

    // One clock edge of the spec's behaviour: arbitration on pre-edge levels, then the debounce
    // decision "last D synchronized samples all differ from the current level".
    task automatic model_step();
        logic [3:0] req, deb_new, rise, keep;
        bit         all_dis;
`ifdef SW_TOGGLE_EN
        req = m_tog;
`else
        req = m_deb;
`endif
        keep = 4'hF;
        if (m_rearm) begin
            m_out = '0;
            if (m_deb == 4'b0000) m_rearm = 1'b0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                keep    = 4'b0001 << m_owner;
                m_out   = '0;
                m_owner = -1;
                m_rearm = 1'b1;
            end
        end else if (req != 4'b0000) begin
            for (int c = 3; c >= 0; c--) if (req[c]) m_owner = c;
            m_out = 4'b0001 << m_owner;
            keep  = m_out;
        end
        m_hist.push_front(cur_btn());
        void'(m_hist.pop_back());
        deb_new = m_deb;
        for (int c = 0; c < 4; c++) begin
            all_dis = 1'b1;
            for (int j = 2; j < D + 2; j++) if (m_hist[j][c] == m_deb[c]) all_dis = 1'b0;
            if (all_dis) deb_new[c] = ~m_deb[c];
        end
        rise  = deb_new & ~m_deb;
        m_tog = (m_tog ^ rise) & keep;
        m_deb = deb_new;
    endtask

    // Advance one cycle; returns at the following falling edge, where outputs are compared.
    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else       model_step();
        @(negedge clk);
        check("model", get_out(), model_out());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at a falling edge; one clock of reset, released at the next falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_async", get_out(), 5'b00000);
        model_clear();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[14];
    logic [4:0] o;
    bit         seen;

    initial begin
        tbl[0]  = '{4'b0000, 5'b00000};
        tbl[1]  = '{4'b0010, 5'b10010};
        tbl[2]  = '{4'b0110, 5'b10010};
        tbl[3]  = '{4'b0100, 5'b10000};
        tbl[4]  = '{4'b0000, 5'b00000};
        tbl[5]  = '{4'b1001, 5'b10001};
        tbl[6]  = '{4'b1000, 5'b10000};
        tbl[7]  = '{4'b0000, 5'b00000};
        tbl[8]  = '{4'b0100, 5'b10100};
        tbl[9]  = '{4'b0101, 5'b10100};
        tbl[10] = '{4'b0001, 5'b10000};
        tbl[11] = '{4'b0000, 5'b00000};
        tbl[12] = '{4'b1000, 5'b11000};
        tbl[13] = '{4'b0000, 5'b00000};

        reset = 1'b1;
        set_btn(4'b0000);
        model_clear();
        @(negedge clk);
        check("reset_state", get_out(), 5'b00000);
        tick();
        reset = 1'b0;

        // Debounce accept: s1_o and lock_o rise on the 7th edge after the press, not before.
        set_btn(4'b0010);
        ticks(6);
        check("accept_early", get_out(), 5'b00000);
        tick();
        check("accept_s1", get_out(), 5'b10010);
        set_btn(4'b0000);
        ticks(6);
        check("release_early", get_out(), 5'b10010);
        tick();
        check("release_s1", get_out(), 5'b10000);
        tick();
        check("release_idle", get_out(), 5'b00000);

        // Glitch rejection: two 3-cycle pulses split by one low cycle never reach the output.
        do_reset();
        seen = 1'b0;
        set_btn(4'b0100);
        ticks(3);
        set_btn(4'b0000);
        tick();
        set_btn(4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= sw.s2_o | sw.lock_o;
        end
        set_btn(4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= sw.s2_o | sw.lock_o;
        end
        check("glitch_reject", {31'd0, seen}, 32'd0);

        // Reset mid-grant: outputs drop at once; held button re-debounced from zero.
        do_reset();
        set_btn(4'b0010);
        ticks(8);
        check("pre_reset_grant", get_out(), 5'b10010);
        do_reset();
        ticks(6);
        check("post_reset_early", get_out(), 5'b00000);
        tick();
        check("post_reset_s1", get_out(), 5'b10010);
        set_btn(4'b0000);
        ticks(10);

`ifndef SW_TOGGLE_EN
        // Priority and re-arm: stop stays masked until it is itself released.
        do_reset();
        set_btn(4'b1001);
        ticks(7);
        check("prio_s0", get_out(), 5'b10001);
        set_btn(4'b1000);
        ticks(12);
        check("prio_rearm", get_out(), 5'b10000);
        set_btn(4'b0000);
        ticks(8);
        check("prio_idle", get_out(), 5'b00000);

        for (int i = 0; i < 14; i++) begin
            set_btn(tbl[i].btn);
            ticks(10);
            check($sformatf("vec%0d", i), get_out(), tbl[i].exp);
        end
`else
        // Toggle: one press enters edit mode, a second press leaves it.
        do_reset();
        set_btn(4'b1000);
        ticks(10);
        check("tog_press1", get_out(), 5'b11000);
        set_btn(4'b0000);
        ticks(10);
        check("tog_held", get_out(), 5'b11000);
        set_btn(4'b1000);
        ticks(10);
        o = get_out();
        check("tog_press2_stop", {31'd0, o[3]}, 32'd0);
        set_btn(4'b0000);
        ticks(10);
        check("tog_release2", get_out(), 5'b00000);
`endif

        // Randomized button activity, compared every cycle against the model.
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 2) == 0) set_btn(4'($urandom_range(0, 15)));
            else                           set_btn(cur_btn() ^ (4'b0001 << $urandom_range(0, 3)));
            ticks($urandom_range(1, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
